// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_BUSY_IF = 2'b01,
      ARB_BUSY_D  = 2'b10,
      ARB_DRAIN   = 2'b11
   } arb_state_e;

   localparam int STARVE_LIMIT_DEF = 4;
   localparam int STREAK_W         = 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

   function automatic logic [STREAK_W-1:0] streak_next(input logic [STREAK_W-1:0] cur,
                                                        input logic [STREAK_W-1:0] limit);
      return (cur >= limit) ? limit : cur + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// rtl/mem_arb_starve_ctr.sv - saturating count of data grants taken while fetch is waiting
module mem_arb_starve_ctr
   import mem_port_arbiter_pkg::*;
#(
   parameter int LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic data_grant_i,
   input  logic fetch_grant_i,
   input  logic if_req_i,
   output logic at_limit_o
);

   localparam logic [STREAK_W-1:0] LIMIT_V = STREAK_W'(LIMIT);

   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;

   // A data grant with no fetch waiting means fetch was not starved, so the streak restarts.
   always_comb begin
      streak_d = streak_q;
      if (fetch_grant_i) begin
         streak_d = '0;
      end else if (data_grant_i) begin
         streak_d = if_req_i ? streak_next(streak_q, LIMIT_V) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign at_limit_o = (streak_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter of the unified memory between fetch and data
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_misaligned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       req_q;
   logic       req_d;
   mem_cmd_t   cmd_q;
   mem_cmd_t   cmd_d;

   logic d_valid;
   logic f_valid;
   logic at_limit;
   logic data_grant;
   logic fetch_grant;
   logic if_ready_c;
   logic d_ready_c;

   assign d_valid = d_req & ~d_misaligned & ~flush;
   assign f_valid = if_req & ~flush;

   mem_arb_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve_ctr (
      .clk          (clk),
      .rst          (rst),
      .data_grant_i (data_grant),
      .fetch_grant_i(fetch_grant),
      .if_req_i     (if_req),
      .at_limit_o   (at_limit)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      cmd_d       = cmd_q;
      data_grant  = 1'b0;
      fetch_grant = 1'b0;
      if_ready_c  = 1'b0;
      d_ready_c   = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (d_valid && !(f_valid && at_limit)) begin
               data_grant  = 1'b1;
               state_d     = ARB_BUSY_D;
               req_d       = 1'b1;
               cmd_d.we    = d_we;
               cmd_d.addr  = d_addr;
               cmd_d.wdata = d_wdata;
            end else if (f_valid) begin
               fetch_grant = 1'b1;
               state_d     = ARB_BUSY_IF;
               req_d       = 1'b1;
               cmd_d.we    = 1'b0;
               cmd_d.addr  = if_addr;
               cmd_d.wdata = '0;
            end
         end
         ARB_BUSY_IF: begin
            if (mem_ready) begin
               if_ready_c = ~flush;
               req_d      = 1'b0;
               state_d    = ARB_IDLE;
            end else if (flush) begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_BUSY_D: begin
            // A flushed store still lands in memory; only the completion to the pipe is dropped.
            if (mem_ready) begin
               d_ready_c = ~flush;
               req_d     = 1'b0;
               state_d   = ARB_IDLE;
            end else if (flush) begin
               state_d = ARB_DRAIN;
            end
         end
         ARB_DRAIN: begin
            if (mem_ready) begin
               req_d   = 1'b0;
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         req_q   <= 1'b0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cmd_q   <= cmd_d;
      end
   end

   // Ready is masked during reset so an abandoned access can never complete into the pipe.
   assign if_ready  = if_ready_c & ~rst;
   assign d_ready   = d_ready_c & ~rst;
   assign if_rdata  = if_ready ? mem_rdata : '0;
   assign d_rdata   = d_ready ? mem_rdata : '0;
   assign if_stall  = if_req & ~if_ready & ~flush;
   assign d_stall   = d_req & ~d_misaligned & ~d_ready & ~flush;

   assign mem_req   = req_q;
   assign mem_we    = cmd_q.we;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single-ported unified memory between instruction fetch and the memory stage's load/store traffic. It sequences one outstanding memory transaction at a time and generates the stall signals that gate the fetch and memory pipeline stages (their clk_en). It also honours writeback-stage flushes (exception / rfe) so that killed requests never return data into the pipe.

Parameters:
STARVE_LIMIT, 4, maximum consecutive data grants while fetch is waiting before fetch is forced to win one grant (range 1..15).

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  exc_in_wb || rfe_in_wb from writeback; kills pending and in-flight requests
if_req  in  1  fetch requests a word
if_addr  in  32  fetch address (word aligned)
if_ready  out  1  fetch data valid this cycle
if_rdata  out  32  fetch data
if_stall  out  1  fetch stage must hold
d_req  in  1  memory stage has a load or store (is_load || is_store, not bubble)
d_we  in  1  1 = store
d_misaligned  in  1  is_misaligned; request is ignored (exception path handles it)
d_addr  in  32  data address
d_wdata  in  32  store data
d_ready  out  1  data access complete this cycle
d_rdata  out  32  load data
d_stall  out  1  memory stage must hold (drives its clk_en low)
mem_req  out  1  request to memory, held until mem_ready
mem_we  out  1  write enable
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_ready  in  1  one-cycle completion pulse from memory; mem_rdata valid with it
mem_rdata  in  32  read data

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D, DRAIN. Encoding: 2 bits.
- d_valid = d_req & ~d_misaligned & ~flush. f_valid = if_req & ~flush.
- IDLE grant rules, evaluated every cycle:
  - d_valid and not (f_valid & streak == STARVE_LIMIT): grant data → BUSY_D.
  - Else if f_valid: grant fetch → BUSY_IF.
  - Else stay in IDLE.
- On grant, register mem_req=1 and the winner's addr/we/wdata. Fetch grants use mem_we=0 and mem_wdata=0. These registers stay stable until mem_ready is sampled.
- Streak counter (4 bits, saturating at STARVE_LIMIT):
  - +1 on a data grant while if_req is high.
  - Cleared on a fetch grant, and on a data grant while if_req is low.
- BUSY_IF:
  - mem_ready & ~flush: if_ready=1 and if_rdata=mem_rdata (combinational, same cycle); mem_req←0; → IDLE.
  - flush & ~mem_ready: → DRAIN.
  - flush & mem_ready: if_ready stays 0; → IDLE.
- BUSY_D: same as BUSY_IF, using d_ready/d_rdata. A flushed store still completes at the memory; only d_ready is suppressed.
- DRAIN: mem_req is held; if_ready and d_ready are 0. On mem_ready → IDLE.
- Latency and throughput:
  - Minimum 2 cycles from an IDLE grant to ready (grant cycle plus a one-cycle-latency memory).
  - A one-cycle IDLE gap follows every completion; no back-to-back grants.
- Stalls (combinational):
  - if_stall = if_req & ~if_ready.
  - d_stall = d_req & ~d_misaligned & ~d_ready.
  - Both are 0 while flush=1 (the pipe is being squashed).
- The arbiter never issues a request while in DRAIN. A mem_ready pulse seen in IDLE is ignored.
- Reset values: state=IDLE, streak=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. All ready outputs are 0.
- Reset mid-transaction abandons the access immediately (mem_req=0 on the next cycle). The memory model must tolerate an abandoned request.

Decomposition:
- Shared package holds the state encoding constants (ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_D, ARB_DRAIN) and the STARVE_LIMIT default, for reuse by the pipeline top and the bench.
- Optional sub-module mem_arb_starve_ctr (saturating streak counter).
- Otherwise a single module of about 180 lines.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100; memory replies mem_ready one cycle after mem_req with 0xDEADBEEF → if_ready=1, if_rdata=0xDEADBEEF on the 2nd cycle after the request; if_stall=1 before that.
- Contention: if_req and d_req (load 0x2000) raised in the same IDLE cycle → mem_addr=0x2000 first; fetch granted after the data completes; d_stall deasserts on d_ready.
- Starvation with STARVE_LIMIT=4: d_req held continuously with if_req=1 → exactly 4 data grants, then 1 fetch grant, then the streak restarts at 0.
- Flush in flight: fetch granted, flush pulsed before mem_ready → DRAIN; if_ready never asserts; mem_req stays high until mem_ready; then IDLE and a new grant is possible.
- Misaligned / flushed data: d_req=1 with d_misaligned=1 → no data grant and d_stall=0. d_req=1 with flush=1 in IDLE → no grant that cycle.
- Reset in BUSY_D (store 0x3000, 0x55): rst pulsed → next cycle mem_req=0, mem_addr=0, state IDLE, and no d_ready even if mem_ready then arrives.
